// File: rtl/scaler_gate_counter.sv
// Gated edge counter for one trigger scaler channel: counts scaler pulses per gate window
// and hands the latched total to readout via valid/ack. Define SCALER_PPS_SYNC_EN for PPS-bounded windows.
module scaler_gate_counter #(
    parameter int COUNT_WIDTH = 16,
    parameter int GATE_WIDTH  = 28,
    parameter int GATE_CYCLES = 250000000
) (
    input  logic                   clk250_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   scal_i,
    input  logic                   ack_i,
`ifdef SCALER_PPS_SYNC_EN
    input  logic                   pps_i,
`endif
    output logic [COUNT_WIDTH-1:0] scaler_o,
    output logic                   valid_o,
    output logic                   overrun_o,
    output logic                   gate_o
);

    // state | meaning
    // IDLE  | counters held at 0, waiting for enable_i
    // SYNC  | PPS build only: enabled, waiting for the first pps_i to open a window
    // RUN   | window open, counting edges and gate cycles
    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

`ifdef SCALER_PPS_SYNC_EN
    // One extra bit so the watchdog limit still fits when GATE_CYCLES is near 2^GATE_WIDTH.
    localparam int GCW = GATE_WIDTH + 1;
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES + GATE_CYCLES / 16 - 1);
`else
    localparam int GCW = GATE_WIDTH;
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);
`endif
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                 state;
    logic                   scal_q;
    logic                   edge_det;
    logic                   term;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_sum;
    logic [GCW-1:0]         gate_cnt;

    always_comb begin
        edge_det  = scal_i & ~scal_q;
        count_sum = (count == COUNT_MAX) ? count : count + COUNT_WIDTH'(edge_det);
`ifdef SCALER_PPS_SYNC_EN
        term      = (state == RUN) && (pps_i || (gate_cnt == GATE_LAST));
`else
        term      = (state == RUN) && (gate_cnt == GATE_LAST);
`endif
    end

    assign gate_o = term;

    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            scal_q    <= 1'b0;
            count     <= '0;
            gate_cnt  <= '0;
            scaler_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            scal_q <= scal_i;

            // An ack on the terminal cycle consumes the old value, so only an unacked one overruns.
            if (term) begin
                scaler_o <= count_sum;
                valid_o  <= 1'b1;
                if (valid_o && !ack_i)
                    overrun_o <= 1'b1;
            end else if (ack_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    count    <= '0;
                    gate_cnt <= '0;
                    if (enable_i) begin
`ifdef SCALER_PPS_SYNC_EN
                        state <= SYNC;
`else
                        state <= RUN;
`endif
                    end
                end
`ifdef SCALER_PPS_SYNC_EN
                SYNC: begin
                    count    <= '0;
                    gate_cnt <= '0;
                    if (!enable_i)
                        state <= IDLE;
                    else if (pps_i)
                        state <= RUN;
                end
`endif
                RUN: begin
                    // A completed window still latches even if enable_i falls on its last cycle.
                    if (term || !enable_i) begin
                        count    <= '0;
                        gate_cnt <= '0;
                        if (!enable_i)
                            state <= IDLE;
                    end else begin
                        count    <= count_sum;
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    gate_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_gate_counter.sv
// Directed bench for scaler_gate_counter: a 16-cycle-window instance and a 4-bit, 48-cycle instance.
`timescale 1ns/1ps
module tb_scaler_gate_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, scal, ack, pps;
    logic        enable2, scal2;
    logic [15:0] scaler;
    logic        valid, overrun, gate;
    logic [3:0]  scaler2;
    logic        valid2, overrun2, gate2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    scaler_gate_counter #(.COUNT_WIDTH(16), .GATE_WIDTH(8), .GATE_CYCLES(16)) dut (
        .clk250_i (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .scal_i   (scal),
        .ack_i    (ack),
`ifdef SCALER_PPS_SYNC_EN
        .pps_i    (pps),
`endif
        .scaler_o (scaler),
        .valid_o  (valid),
        .overrun_o(overrun),
        .gate_o   (gate)
    );

    scaler_gate_counter #(.COUNT_WIDTH(4), .GATE_WIDTH(8), .GATE_CYCLES(48)) dut_sat (
        .clk250_i (clk),
        .rst_i    (rst),
        .enable_i (enable2),
        .scal_i   (scal2),
        .ack_i    (1'b0),
`ifdef SCALER_PPS_SYNC_EN
        .pps_i    (pps),
`endif
        .scaler_o (scaler2),
        .valid_o  (valid2),
        .overrun_o(overrun2),
        .gate_o   (gate2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full 16-cycle window starting at gate count 0; ack_cyc < 0 means no ack.
    task automatic run_window(input string tag, input logic [15:0] pat, input int ack_cyc,
                              input int exp_cnt);
        for (int i = 0; i < 16; i++) begin
            scal = pat[i];
            ack  = (i == ack_cyc);
            if (i == 0 || i == 14 || i == 15)
                check({tag, "_gate"}, 32'(gate), 32'(i == 15));
            step();
        end
        ack = 1'b0;
        check({tag, "_scaler"}, 32'(scaler), 32'(exp_cnt));
        check({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; scal = 1'b0; ack = 1'b0; pps = 1'b0;
        enable2 = 1'b0; scal2 = 1'b0;
        step(); step();
        check("rst_scaler", 32'(scaler), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_gate", 32'(gate), 32'd0);
        rst = 1'b0;
        step();

`ifndef SCALER_PPS_SYNC_EN
        enable = 1'b1;
        step();
        run_window("w1_spaced", 16'h1249, -1, 5);
        check("w1_overrun", 32'(overrun), 32'd0);
        run_window("w2_long", 16'h13FF, 2, 2);
        check("w2_overrun", 32'(overrun), 32'd0);
        run_window("w3_termedge", 16'h8124, 0, 4);
        run_window("w4_empty", 16'h0000, 0, 0);
        check("w4_overrun", 32'(overrun), 32'd0);
        run_window("w5", 16'h0002, 0, 1);
        check("w5_overrun", 32'(overrun), 32'd0);
        run_window("w6_noack", 16'h0012, -1, 2);
        check("w6_overrun", 32'(overrun), 32'd1);
        run_window("w7_termack", 16'h0492, 15, 4);
        check("w7_overrun", 32'(overrun), 32'd1);

        // Drop enable after 3 edges; the partial window must not latch.
        for (int i = 0; i < 7; i++) begin
            scal = (i == 1 || i == 3 || i == 5);
            ack  = (i == 0);
            step();
        end
        ack = 1'b0;
        check("drop_acked_valid", 32'(valid), 32'd0);
        enable = 1'b0;
        scal   = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("drop_gate", 32'(gate), 32'd0);
            step();
        end
        check("drop_scaler", 32'(scaler), 32'd4);
        check("drop_valid", 32'(valid), 32'd0);
        enable = 1'b1;
        step();
        run_window("w9_fresh", 16'h0044, -1, 2);
        check("w9_overrun", 32'(overrun), 32'd1);

        // Asynchronous reset in the middle of a window.
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1'b1;
        #1;
        check("arst_scaler", 32'(scaler), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_gate", 32'(gate), 32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        step();

        // Saturation on the 4-bit instance: 20 edges in a 48-cycle window.
        enable2 = 1'b1;
        step();
        for (int i = 0; i < 48; i++) begin
            scal2 = (i < 40) && (i % 2 == 0);
            if (i == 46 || i == 47)
                check("sat_gate", 32'(gate2), 32'(i == 47));
            step();
        end
        scal2 = 1'b0;
        check("sat_scaler", 32'(scaler2), 32'd15);
        check("sat_valid", 32'(valid2), 32'd1);
`else
        // PPS-bounded windows on the 48-cycle instance (watchdog at 51 cycles).
        enable2 = 1'b1;
        step();
        step(); step();
        pps = 1'b1;
        check("pps_first_gate", 32'(gate2), 32'd0);
        step();
        pps = 1'b0;
        check("pps_first_valid", 32'(valid2), 32'd0);
        for (int i = 0; i < 20; i++) begin
            pps   = (i == 19);
            scal2 = (i == 2 || i == 5 || i == 8);
            if (i == 18 || i == 19)
                check("pps_w1_gate", 32'(gate2), 32'(i == 19));
            step();
        end
        pps = 1'b0; scal2 = 1'b0;
        check("pps_w1_scaler", 32'(scaler2), 32'd3);
        check("pps_w1_valid", 32'(valid2), 32'd1);
        for (int i = 0; i < 20; i++) begin
            pps   = (i == 19);
            scal2 = (i == 4);
            step();
        end
        pps = 1'b0; scal2 = 1'b0;
        check("pps_w2_scaler", 32'(scaler2), 32'd1);
        check("pps_w2_overrun", 32'(overrun2), 32'd1);
        for (int i = 0; i < 51; i++) begin
            if (i == 49 || i == 50)
                check("pps_wdog_gate", 32'(gate2), 32'(i == 50));
            step();
        end
        check("pps_wdog_scaler", 32'(scaler2), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
